// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and constants for the scoreboarded register file.
//   reg_idx_t  - register index at the default geometry
//   data_t     - register word at the default geometry
//   rf_state_t - CLEAR sweep / RUN operating state
package regfile_pkg;
    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_NUM_REGS   = 32;
    localparam int RF_ADDR_WIDTH = $clog2(RF_NUM_REGS);
    localparam int ZERO_REG      = 0;
    localparam int A0_REG        = 10;
    typedef logic [RF_ADDR_WIDTH-1:0] reg_idx_t;
    typedef logic [RF_DATA_WIDTH-1:0] data_t;
    typedef enum logic {CLEAR, RUN} rf_state_t;
endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/writeback bus of the register file.
//   master (decode/writeback side): drives A1, A2, WE3, A3, WD3, issue_en, issue_rd
//   slave  (register file side):    drives ready, RD1, RD2, stall, a0
interface regfile_sb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  ready;
    logic [ADDR_WIDTH-1:0] A1;
    logic [ADDR_WIDTH-1:0] A2;
    logic [DATA_WIDTH-1:0] RD1;
    logic [DATA_WIDTH-1:0] RD2;
    logic                  WE3;
    logic [ADDR_WIDTH-1:0] A3;
    logic [DATA_WIDTH-1:0] WD3;
    logic                  issue_en;
    logic [ADDR_WIDTH-1:0] issue_rd;
    logic                  stall;
    logic [DATA_WIDTH-1:0] a0;
    modport master (
        input  ready, RD1, RD2, stall, a0,
        output A1, A2, WE3, A3, WD3, issue_en, issue_rd
    );
    modport slave (
        output ready, RD1, RD2, stall, a0,
        input  A1, A2, WE3, A3, WD3, issue_en, issue_rd
    );
endinterface

// File: rtl/regfile_sb_scoreboard.sv
// rf_scoreboard: per-register busy bits and the decode stall.
//   clk, rst         - clock, synchronous active-high reset (drops all busy bits)
//   set_en, set_idx  - producer issued to set_idx (caller excludes index 0)
//   clr_en, clr_idx  - writeback to clr_idx releases it (caller excludes index 0)
//   rs1, rs2         - source indices being read by decode
//   stall            - a non-zero source is still outstanding
module rf_scoreboard #(
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_idx,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_idx,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  stall
);
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                free1, free2;

    // Set is applied after clear so a re-issue on the same edge stays outstanding.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_idx] = 1'b0;
        if (set_en) busy_d[set_idx] = 1'b1;
    end

    // A source being written this cycle is already satisfied by bypass,
    // unless the same cycle also re-issues a newer producer of it.
    assign free1 = clr_en && clr_idx == rs1 && !(set_en && set_idx == rs1);
    assign free2 = clr_en && clr_idx == rs2 && !(set_en && set_idx == rs2);
    assign stall = (rs1 != '0 && busy_q[rs1] && !free1) || (rs2 != '0 && busy_q[rs2] && !free2);

    always_ff @(posedge clk)
        busy_q <= rst ? '0 : busy_d;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with hard-wired x0, write-first bypass,
// post-reset clear sweep and a busy-bit scoreboard.
//   clk, rst - clock, synchronous active-high reset (restarts the clear sweep)
//   bus      - slave side of regfile_sb_if: read ports A1/A2 -> RD1/RD2,
//              writeback WE3/A3/WD3, issue_en/issue_rd, ready, stall, a0 debug view
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS),
    parameter int DEBUG_REG  = A0_REG
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] DBG  = ADDR_WIDTH'(DEBUG_REG);
    localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(ZERO_REG);

    rf_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic                  wr, iss, sb_stall;

    assign wr  = ready_q && bus.WE3 && bus.A3 != ZERO;
    assign iss = ready_q && bus.issue_en && bus.issue_rd != ZERO;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ready_d   = ready_q;
        regs_d    = regs_q;
        if (state_q == CLEAR) begin
            regs_d[clr_cnt_q] = '0;
            // The counter holds at the last index instead of wrapping.
            clr_cnt_d = clr_cnt_q == LAST ? clr_cnt_q : clr_cnt_q + ADDR_WIDTH'(1);
            state_d   = clr_cnt_q == LAST ? RUN : CLEAR;
            ready_d   = clr_cnt_q == LAST;
        end else if (wr) begin
            regs_d[bus.A3] = bus.WD3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= ADDR_WIDTH'(1);
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
        end
        regs_q <= regs_d;
    end

    // x0 reads zero; a same-cycle writeback to the index is forwarded.
    assign bus.RD1   = (!ready_q || bus.A1 == ZERO) ? '0 : (wr && bus.A3 == bus.A1) ? bus.WD3 : regs_q[bus.A1];
    assign bus.RD2   = (!ready_q || bus.A2 == ZERO) ? '0 : (wr && bus.A3 == bus.A2) ? bus.WD3 : regs_q[bus.A2];
    assign bus.a0    = (!ready_q || DBG == ZERO) ? '0 : (wr && bus.A3 == DBG) ? bus.WD3 : regs_q[DBG];
    assign bus.ready = ready_q;
    assign bus.stall = ready_q && sb_stall;

    rf_scoreboard #(.NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH)) u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_en  (iss),
        .set_idx (bus.issue_rd),
        .clr_en  (wr),
        .clr_idx (bus.A3),
        .rs1     (bus.A1),
        .rs2     (bus.A2),
        .stall   (sb_stall)
    );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vector table plus reset-sweep, mid-sweep and mid-run reset sequences.
module tb_regfile_sb;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    regfile_sb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        reg_idx_t a1, a2, a3, ird;
        logic     we, ien;
        data_t    wd;
        data_t    rd1, rd2, a0;
        logic     stall;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(reg_idx_t a1, reg_idx_t a2, logic we, reg_idx_t a3, data_t wd,
                                logic ien, reg_idx_t ird, data_t rd1, data_t rd2, logic stall, data_t a0);
        vec_t v;
        v.a1 = a1; v.a2 = a2; v.we = we; v.a3 = a3; v.wd = wd; v.ien = ien; v.ird = ird;
        v.rd1 = rd1; v.rd2 = rd2; v.stall = stall; v.a0 = a0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input reg_idx_t a1, input reg_idx_t a2, input logic we, input reg_idx_t a3,
                         input data_t wd, input logic ien, input reg_idx_t ird);
        bus.A1 = a1; bus.A2 = a2; bus.WE3 = we; bus.A3 = a3; bus.WD3 = wd;
        bus.issue_en = ien; bus.issue_rd = ird;
    endtask

    // Counts rising edges after rst deasserts until ready, bounded.
    task automatic wait_ready(input string name);
        int n = 0;
        while (!bus.ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, n, 31);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        vecs[0]  = mk(0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(5, 5, 1, 5, 32'h12345678, 0, 0, 32'h12345678, 32'h12345678, 0, 0);
        vecs[4]  = mk(5, 5, 0, 0, 0, 0, 0, 32'h12345678, 32'h12345678, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
        vecs[6]  = mk(0, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[7]  = mk(0, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[8]  = mk(0, 7, 1, 7, 32'hA5, 0, 0, 0, 32'hA5, 0, 0);
        vecs[9]  = mk(0, 7, 0, 0, 0, 0, 0, 0, 32'hA5, 0, 0);
        vecs[10] = mk(0, 0, 1, 10, 32'h55, 0, 0, 0, 0, 0, 32'h55);
        vecs[11] = mk(10, 0, 0, 0, 0, 0, 0, 32'h55, 0, 0, 32'h55);
        vecs[12] = mk(0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 32'h55);
        vecs[13] = mk(0, 0, 1, 3, 32'h33, 1, 3, 0, 0, 0, 32'h55);
        vecs[14] = mk(3, 0, 0, 0, 0, 0, 0, 32'h33, 0, 1, 32'h55);
        vecs[15] = mk(3, 0, 1, 3, 32'h44, 0, 0, 32'h44, 0, 0, 32'h55);
        vecs[16] = mk(3, 0, 0, 0, 0, 0, 0, 32'h44, 0, 0, 32'h55);
        vecs[17] = mk(0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 32'h55);
        vecs[18] = mk(9, 0, 1, 9, 32'h99, 1, 9, 32'h99, 0, 1, 32'h55);
        vecs[19] = mk(9, 0, 1, 9, 32'h9A, 0, 0, 32'h9A, 0, 0, 32'h55);

        // Power-on sweep: outputs held at zero while clearing.
        pulse_rst();
        drive(10, 0, 1, 10, 32'hBAD, 1, 6);
        #1;
        chk("clear_ready", bus.ready, 0);
        chk("clear_rd1", bus.RD1, 0);
        chk("clear_a0", bus.a0, 0);
        chk("clear_stall", bus.stall, 0);
        wait_ready("sweep_len_por");

        // Reset mid-sweep restarts the count from index 1.
        pulse_rst();
        repeat (10) @(posedge clk);
        pulse_rst();
        wait_ready("sweep_len_restart");
        @(negedge clk);
        drive(0, 6, 0, 0, 0, 0, 0);
        #1;
        chk("clear_issue_ignored", bus.stall, 0);
        chk("clear_write_ignored", bus.a0, 0);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(vecs[i].a1, vecs[i].a2, vecs[i].we, vecs[i].a3, vecs[i].wd, vecs[i].ien, vecs[i].ird);
            #1;
            chk($sformatf("v%0d_rd1", i), bus.RD1, vecs[i].rd1);
            chk($sformatf("v%0d_rd2", i), bus.RD2, vecs[i].rd2);
            chk($sformatf("v%0d_stall", i), {31'b0, bus.stall}, {31'b0, vecs[i].stall});
            chk($sformatf("v%0d_a0", i), bus.a0, vecs[i].a0);
        end

        // Mid-run reset with x10 written and busy[4] set.
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1, 4);
        @(negedge clk);
        drive(4, 0, 0, 0, 0, 0, 0);
        #1;
        chk("busy4_set", bus.stall, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(10, 4, 1, 12, 32'hBAD, 1, 12);
        #1;
        chk("midrun_clear_rd1", bus.RD1, 0);
        chk("midrun_clear_stall", bus.stall, 0);
        chk("midrun_clear_ready", bus.ready, 0);
        wait_ready("sweep_len_midrun");
        @(negedge clk);
        drive(12, 4, 0, 0, 0, 0, 0);
        #1;
        chk("midrun_a0", bus.a0, 0);
        chk("midrun_busy4_dropped", bus.stall, 0);
        chk("midrun_rd1_x12", bus.RD1, 0);
        @(negedge clk);
        drive(0, 12, 0, 0, 0, 0, 0);
        #1;
        chk("midrun_issue12_ignored", bus.stall, 0);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive(reg_idx_t'(i), reg_idx_t'(31 - i), 0, 0, 0, 0, 0);
            #1;
            chk($sformatf("zero_rd1_x%0d", i), bus.RD1, 0);
            chk($sformatf("zero_rd2_x%0d", 31 - i), bus.RD2, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
